// File: rtl/perceptron_scheduler.sv
// ---------------------------------------------------------------------------
// perceptron_scheduler
// Time-multiplexes one shared perceptron (forward + backward majority gate)
// across NUM_NEURONS neuron slots. An accepted start runs a forward pass and,
// when bwd_en_in was set, a backward pass. One neuron is issued per cycle.
// Results are collected into the layer-wide vectors fwd_out / bwd_out.
//
// Parameters
//   NUM_NEURONS  neuron slots per layer (>=1), 3-bit fan-in per neuron
//   PE_LAT       cycles from driving pe_* to sampling pe_fout/pe_bout (0..3)
//
// Ports
//   clk_in, rst_n_in        clock, asynchronous active-low reset
//   start_in, bwd_en_in     start request (IDLE only) and backward-pass enable
//   fwd_in, ctrl_in, bwd_in layer operands, latched on accepted start
//   pe_fcontrol/pe_fin/pe_bin  drive the shared perceptron
//   pe_fout/pe_bout         perceptron results
//   busy_out, done_out      pass in progress / one-cycle completion pulse
//   fwd_out, bwd_out        per-neuron results, held until next start
//   cycle_cnt_out           busy-cycle counter, present only when
//                           PERCEPTRON_SCHED_CYCLE_CNT_EN is defined
// ---------------------------------------------------------------------------
module perceptron_scheduler #(
    parameter int unsigned NUM_NEURONS = 4,
    parameter int unsigned PE_LAT      = 1
) (
    input  logic                     clk_in,
    input  logic                     rst_n_in,
    input  logic                     start_in,
    input  logic                     bwd_en_in,
    input  logic [3*NUM_NEURONS-1:0] fwd_in,
    input  logic [NUM_NEURONS-1:0]   ctrl_in,
    input  logic [3*NUM_NEURONS-1:0] bwd_in,
    output logic                     pe_fcontrol,
    output logic [2:0]               pe_fin,
    output logic [2:0]               pe_bin,
    input  logic                     pe_fout,
    input  logic                     pe_bout,
    output logic                     busy_out,
    output logic                     done_out,
    output logic [NUM_NEURONS-1:0]   fwd_out,
    output logic [NUM_NEURONS-1:0]   bwd_out
`ifdef PERCEPTRON_SCHED_CYCLE_CNT_EN
    ,
    output logic [15:0]              cycle_cnt_out
`endif
);

    localparam int unsigned IDX_W    = $clog2(NUM_NEURONS) + 1;
    localparam int unsigned DRN_W    = 2;
    localparam int unsigned DRN_LAST = (PE_LAT == 0) ? 0 : PE_LAT - 1;
    localparam int unsigned PIPE_D   = (PE_LAT == 0) ? 1 : PE_LAT;
    localparam int unsigned ENT_W    = IDX_W + 2;   // {valid, is_bwd, index}

    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_NEURONS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_FWD,
        S_FWD_DRAIN,
        S_BWD,
        S_BWD_DRAIN,
        S_DONE
    } state_t;

    state_t                   r_state;
    logic [IDX_W-1:0]         r_idx;
    logic [DRN_W-1:0]         r_dcnt;
    logic                     r_bwd_en;
    logic [3*NUM_NEURONS-1:0] r_fwd;
    logic [NUM_NEURONS-1:0]   r_ctrl;
    logic [3*NUM_NEURONS-1:0] r_bwd;
    logic                     r_pe_fc;
    logic [2:0]               r_pe_fin;
    logic [2:0]               r_pe_bin;
    logic                     r_busy;
    logic                     r_done;
    logic [NUM_NEURONS-1:0]   r_fwd_out;
    logic [NUM_NEURONS-1:0]   r_bwd_out;
    logic [ENT_W-1:0]         r_pipe [PIPE_D];

    state_t                   w_state_nxt;
    logic [IDX_W-1:0]         w_idx_nxt;
    logic [DRN_W-1:0]         w_dcnt_nxt;
    logic                     w_accept;
    logic                     w_busy_nxt;
    logic [3*NUM_NEURONS-1:0] w_fwd_src;
    logic [NUM_NEURONS-1:0]   w_ctrl_src;
    logic [3*NUM_NEURONS-1:0] w_bwd_src;
    logic [2:0]               w_sel_fin;
    logic [2:0]               w_sel_bin;
    logic                     w_sel_fc;
    logic                     w_pe_fc_nxt;
    logic [2:0]               w_pe_fin_nxt;
    logic [2:0]               w_pe_bin_nxt;
    logic [ENT_W-1:0]         w_iss;
    logic [ENT_W-1:0]         w_cap;

    // State register
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_dcnt  <= w_dcnt_nxt;
        end
    end

    // Next-state logic and next values of the registered perceptron drive
    always_comb begin
        w_state_nxt  = r_state;
        w_idx_nxt    = r_idx;
        w_dcnt_nxt   = r_dcnt;
        w_accept     = 1'b0;
        w_busy_nxt   = 1'b0;
        w_sel_fin    = '0;
        w_sel_bin    = '0;
        w_sel_fc     = 1'b0;
        w_pe_fc_nxt  = 1'b0;
        w_pe_fin_nxt = '0;
        w_pe_bin_nxt = '0;

        unique case (r_state)
            S_IDLE: begin
                if (start_in) begin
                    w_accept    = 1'b1;
                    w_state_nxt = S_FWD;
                    w_idx_nxt   = '0;
                end
            end
            S_FWD: begin
                if (r_idx == IDX_LAST) begin
                    w_dcnt_nxt = '0;
                    if (PE_LAT != 0) begin
                        w_state_nxt = S_FWD_DRAIN;
                    end else if (r_bwd_en) begin
                        w_state_nxt = S_BWD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_FWD_DRAIN: begin
                if (r_dcnt == DRN_W'(DRN_LAST)) begin
                    if (r_bwd_en) begin
                        w_state_nxt = S_BWD;
                        w_idx_nxt   = '0;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_dcnt_nxt = r_dcnt + DRN_W'(1);
                end
            end
            S_BWD: begin
                if (r_idx == IDX_LAST) begin
                    w_dcnt_nxt  = '0;
                    w_state_nxt = (PE_LAT != 0) ? S_BWD_DRAIN : S_DONE;
                end else begin
                    w_idx_nxt = r_idx + IDX_W'(1);
                end
            end
            S_BWD_DRAIN: begin
                if (r_dcnt == DRN_W'(DRN_LAST)) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_dcnt_nxt = r_dcnt + DRN_W'(1);
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase

        w_busy_nxt = (w_state_nxt == S_FWD) || (w_state_nxt == S_FWD_DRAIN) ||
                     (w_state_nxt == S_BWD) || (w_state_nxt == S_BWD_DRAIN);

        // Neuron 0 is driven on the accept edge, before the operands are latched
        w_fwd_src  = (r_state == S_IDLE) ? fwd_in  : r_fwd;
        w_ctrl_src = (r_state == S_IDLE) ? ctrl_in : r_ctrl;
        w_bwd_src  = (r_state == S_IDLE) ? bwd_in  : r_bwd;

        for (int n = 0; n < NUM_NEURONS; n++) begin
            if (w_idx_nxt == IDX_W'(n)) begin
                w_sel_fin = w_fwd_src[3*n +: 3];
                w_sel_bin = w_bwd_src[3*n +: 3];
                w_sel_fc  = w_ctrl_src[n];
            end
        end

        if (w_state_nxt == S_FWD) begin
            w_pe_fin_nxt = w_sel_fin;
            w_pe_fc_nxt  = w_sel_fc;
        end
        if (w_state_nxt == S_BWD) begin
            w_pe_bin_nxt = w_sel_bin;
        end
    end

    // Issue descriptor for the neuron driven in the current cycle
    assign w_iss = {(r_state == S_FWD) || (r_state == S_BWD),
                    (r_state == S_BWD),
                    r_idx};
    // With zero latency the result is sampled in its issue cycle
    assign w_cap = (PE_LAT == 0) ? w_iss : r_pipe[PIPE_D-1];

    // Operand latches, perceptron drive, status, latency pipe and result capture
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_bwd_en  <= 1'b0;
            r_fwd     <= '0;
            r_ctrl    <= '0;
            r_bwd     <= '0;
            r_pe_fc   <= 1'b0;
            r_pe_fin  <= '0;
            r_pe_bin  <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_fwd_out <= '0;
            r_bwd_out <= '0;
            for (int i = 0; i < PIPE_D; i++) begin
                r_pipe[i] <= '0;
            end
        end else begin
            r_pe_fc  <= w_pe_fc_nxt;
            r_pe_fin <= w_pe_fin_nxt;
            r_pe_bin <= w_pe_bin_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= (w_state_nxt == S_DONE);

            if (w_accept) begin
                r_fwd     <= fwd_in;
                r_ctrl    <= ctrl_in;
                r_bwd     <= bwd_in;
                r_bwd_en  <= bwd_en_in;
                r_fwd_out <= '0;
                r_bwd_out <= '0;
            end

            r_pipe[0] <= w_iss;
            for (int i = 1; i < PIPE_D; i++) begin
                r_pipe[i] <= r_pipe[i-1];
            end

            if (w_cap[ENT_W-1]) begin
                for (int n = 0; n < NUM_NEURONS; n++) begin
                    if (w_cap[IDX_W-1:0] == IDX_W'(n)) begin
                        if (w_cap[IDX_W]) begin
                            r_bwd_out[n] <= pe_bout;
                        end else begin
                            r_fwd_out[n] <= pe_fout;
                        end
                    end
                end
            end
        end
    end

`ifdef PERCEPTRON_SCHED_CYCLE_CNT_EN
    logic [15:0] r_cyc_cnt;

    // Busy-cycle counter, saturating, held while idle
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cyc_cnt <= '0;
        end else if (w_accept) begin
            r_cyc_cnt <= '0;
        end else if (r_busy && (r_cyc_cnt != 16'hFFFF)) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
        end
    end

    assign cycle_cnt_out = r_cyc_cnt;
`endif

    assign pe_fcontrol = r_pe_fc;
    assign pe_fin      = r_pe_fin;
    assign pe_bin      = r_pe_bin;
    assign busy_out    = r_busy;
    assign done_out    = r_done;
    assign fwd_out     = r_fwd_out;
    assign bwd_out     = r_bwd_out;

endmodule
